// File: rtl/lifo_stack_pkg.sv
// Shared constants, word type and operation decode for the LIFO stack.
package lifo_stack_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned PTR_W     = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_WIDTH-1:0] word_t;

  // The count holds 0..DEPTH inclusive, so it needs one bit more than the address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; the occupancy count defines validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with registered Data_Out and count-decoded Full/Empty flags.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] Data_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Full,
  output logic             Empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = ptr_width(DEPTH);

  logic [CW-1:0]    count;
  logic [CW-1:0]    top_ptr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] top_word;
  logic             we;
  op_e              op;

  assign Full    = (count == CW'(DEPTH));
  assign Empty   = (count == '0);
  assign top_ptr = count - CW'(1);

  // Push+Pop on an empty stack degrades to a plain push; on a full stack it is a replace.
  always_comb begin
    op = OP_IDLE;
    if (Push && Pop && !Empty) begin
      op = OP_REPLACE;
    end else if (Push && !Full) begin
      op = OP_PUSH;
    end else if (Pop && !Empty) begin
      op = OP_POP;
    end
  end

  always_comb begin
    we    = (op == OP_PUSH) || (op == OP_REPLACE);
    waddr = (op == OP_PUSH) ? count[AW-1:0] : top_ptr[AW-1:0];
  end

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (Clk),
    .we    (we),
    .waddr (waddr),
    .wdata (Data_In),
    .raddr (top_ptr[AW-1:0]),
    .rdata (top_word)
  );

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      count    <= '0;
      Data_Out <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          count <= count + CW'(1);
        end
        OP_POP: begin
          Data_Out <= top_word;
          count    <= top_ptr;
        end
        OP_REPLACE: begin
          Data_Out <= top_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed plan followed by randomized traffic vs a queue model.
module tb_lifo_stack;

  localparam int unsigned W = 4;
  localparam int unsigned D = 8;

  logic         Clk = 1'b0;
  logic         RstN;
  logic         Push;
  logic         Pop;
  logic [W-1:0] Data_In;
  logic [W-1:0] Data_Out;
  logic         Full;
  logic         Empty;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout;

  lifo_stack #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .Push     (Push),
    .Pop      (Pop),
    .Data_In  (Data_In),
    .Data_Out (Data_Out),
    .Full     (Full),
    .Empty    (Empty)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded stack as a queue, top at the back.
  task automatic model_step(input logic rstn, input logic push, input logic pop,
                            input logic [W-1:0] din);
    if (!rstn) begin
      model_q.delete();
      model_dout = '0;
    end else if (push && pop && model_q.size() > 0) begin
      model_dout = model_q[$];
      model_q[model_q.size()-1] = din;
    end else if (push && model_q.size() < D) begin
      model_q.push_back(din);
    end else if (!push && pop && model_q.size() > 0) begin
      model_dout = model_q.pop_back();
    end
  endtask

  task automatic cycle(input string tag, input logic rstn, input logic push,
                       input logic pop, input logic [W-1:0] din);
    RstN    = rstn;
    Push    = push;
    Pop     = pop;
    Data_In = din;
    @(posedge Clk);
    model_step(rstn, push, pop, din);
    #1;
    check({tag, ".dout"},  8'(Data_Out), 8'(model_dout));
    check({tag, ".full"},  8'(Full),     8'(model_q.size() == D));
    check({tag, ".empty"}, 8'(Empty),    8'(model_q.size() == 0));
  endtask

  initial begin
    model_dout = '0;
    RstN = 1'b0; Push = 1'b0; Pop = 1'b0; Data_In = '0;
    #2;

    cycle("reset", 1'b0, 1'b0, 1'b0, 4'h0);
    check("reset.dout_zero", 8'(Data_Out), 8'h00);
    cycle("pop_empty", 1'b1, 1'b0, 1'b1, 4'h0);

    for (int i = 2; i <= 9; i++) cycle("fill", 1'b1, 1'b1, 1'b0, W'(i));
    check("fill.full_set", 8'(Full), 8'h01);
    cycle("overflow", 1'b1, 1'b1, 1'b0, 4'hA);

    for (int i = 0; i < 8; i++) cycle("drain", 1'b1, 1'b0, 1'b1, 4'h0);
    check("drain.last_word", 8'(Data_Out), 8'h02);
    cycle("underflow", 1'b1, 1'b0, 1'b1, 4'h0);

    cycle("push2", 1'b1, 1'b1, 1'b0, 4'h2);
    cycle("push3", 1'b1, 1'b1, 1'b0, 4'h3);
    cycle("replace", 1'b1, 1'b1, 1'b1, 4'h7);
    check("replace.old_top", 8'(Data_Out), 8'h03);
    cycle("pop_rep", 1'b1, 1'b0, 1'b1, 4'h0);
    check("pop_rep.new_top", 8'(Data_Out), 8'h07);
    cycle("pop_last", 1'b1, 1'b0, 1'b1, 4'h0);
    cycle("pp_empty", 1'b1, 1'b1, 1'b1, 4'h7);
    cycle("pop_pp", 1'b1, 1'b0, 1'b1, 4'h0);

    for (int i = 0; i < 8; i++) cycle("fill2", 1'b1, 1'b1, 1'b0, W'(i + 8));
    cycle("full_replace", 1'b1, 1'b1, 1'b1, 4'h5);
    check("full_replace.old_top", 8'(Data_Out), 8'h0F);
    cycle("pop_fr", 1'b1, 1'b0, 1'b1, 4'h0);
    check("pop_fr.new_top", 8'(Data_Out), 8'h05);

    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b1, 1'b0, W'(i + 1));
    cycle("mid_rst", 1'b0, 1'b1, 1'b0, 4'hC);
    cycle("pop_after_rst", 1'b1, 1'b0, 1'b1, 4'h0);
    check("pop_after_rst.dout_zero", 8'(Data_Out), 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic r, pu, po;
      r  = ($urandom_range(0, 59) != 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      cycle("rand", r, pu, po, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous LIFO stack, 8 entries x 4 bits, with registered data output and Full/Empty status flags.
- Used as a small local storage block.
- Single clock domain; no external memory.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of entries (power of two, >= 2).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- RstN  in  1  reset is synchronous and active-low.
- Push  in  1  write Data_In onto the top of the stack this cycle.
- Pop  in  1  remove the top entry and present it on Data_Out this cycle.
- Data_In  in  WIDTH  word to push.
- Data_Out  out  WIDTH  registered; last popped word.
- Full  out  1  high when the stack holds DEPTH entries.
- Empty  out  1  high when the stack holds 0 entries.

Behaviour:
- State:
  - Storage array mem[0..DEPTH-1].
  - Occupancy counter count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
  - Top entry is mem[count-1].
- Flags:
  - Full = (count == DEPTH); Empty = (count == 0).
  - Both are decoded from the registered count only, so there is no combinational path from Push/Pop.
- Reset (RstN=0 sampled at a rising edge):
  - count <= 0 and Data_Out <= 0, giving Empty=1 and Full=0.
  - mem contents are don't-care and are not cleared.
  - Reset overrides Push/Pop in the same cycle.
  - Mid-operation reset discards all stored entries.
- Push only (Push=1, Pop=0):
  - If not Full: mem[count] <= Data_In; count <= count+1.
  - If Full: the push is dropped; contents, count and Data_Out are unchanged (no overwrite, no wrap).
- Pop only (Pop=1, Push=0):
  - If not Empty: Data_Out <= mem[count-1]; count <= count-1.
  - If Empty: ignored; Data_Out holds its previous value and count stays 0.
- Push and Pop together:
  - If not Empty: Data_Out <= mem[count-1] and mem[count-1] <= Data_In; count is unchanged. This is a replace-top operation and is legal even when Full.
  - If Empty: treated as push only (count becomes 1); Data_Out is unchanged.
- Idle (both low): no change; Data_Out holds.
- Latency:
  - A pushed word is poppable on the next cycle.
  - Data_Out is valid one cycle after the Pop edge.
  - Flags update one cycle after the operation.
- Data_In is sampled only when a push is actually accepted.

Decomposition:
- Shared package lifo_stack_pkg: WIDTH/DEPTH defaults, a derived pointer-width constant PTR_W = $clog2(DEPTH)+1, and the word typedef.
- One sub-module, lifo_stack_mem: DEPTH x WIDTH register file with one synchronous write port and one asynchronous read port (read address count-1).
- Top level holds the count, the flags, the operation decode and the Data_Out register.

Test Plan:
- Reset: hold RstN=0 for 1 cycle -> Empty=1, Full=0, Data_Out=0. Then Pop with RstN=1 -> Data_Out stays 0, Empty stays 1.
- Fill/overflow:
  - Push 2,3,...,9 on 8 consecutive cycles -> Full=1 after the 8th push, Empty=0.
  - A 9th push of 10 -> ignored, Full stays 1.
- Drain/underflow:
  - 8 consecutive pops -> Data_Out = 9,8,7,6,5,4,3,2 (one per cycle); Empty=1 after the last pop.
  - A 9th pop -> Data_Out holds 2, count stays 0.
- Simultaneous Push/Pop:
  - With stack {2,3}, Push=Pop=1, Data_In=7 -> Data_Out=3, stack {2,7}, count 2; next pop -> 7.
  - With empty stack, Push=Pop=1, Data_In=7 -> Empty=0, Data_Out unchanged.
- Full replace: with Full, Push=Pop=1, Data_In=5 -> Data_Out = old top, Full stays 1; next pop -> 5.
- Mid-operation reset: push 3 words, assert RstN=0 while Push=1 -> Empty=1, Data_Out=0, pushed word not stored; subsequent pop leaves Data_Out=0.
